dense_layer_engine: RTL and testbench
=====================================

// Module: dense_layer_engine
// PURPOSE
//  Parametrised fully-connected layer for the AXI Stream coprocessor; successor to the fixed 64x7 -> 2-neuron hidden layer.
//  Computes OUT[r][n] = act( sat( (sum_i X[r][i]*W[i][n]) >> ACC_SHIFT + B[n] ) ) for every row r and neuron n.
//  act is a sigmoid LUT read, or identity when act_bypass=1.
//  Sits between the X/weight/sigmoid RAMs and the result RAM. Output feeds the next layer or the predictor.
// PARAMETERS
//  WIDTH        8   data bits per RAM location (unsigned)
//  N_IN         7   inputs per row (features)
//  N_NEURON     2   neurons (output columns)
//  N_ROWS       64  rows processed per Start
//  ACC_SHIFT    8   right shift applied to the accumulated sum before the bias add
//  X_AW         9   X RAM address bits;      must hold N_ROWS*N_IN
//  W_AW         4   weight RAM address bits; must hold (N_IN+1)*N_NEURON
//  SIGM_AW      8   sigmoid LUT address bits
//  RES_AW       7   result RAM address bits; must hold N_ROWS*N_NEURON
// PORTS
//  clk              in   1        single clock, all logic on posedge
//  reset            in   1        synchronous, active-high
//  Start            in   1        level; sampled in IDLE only
//  act_bypass       in   1        sampled at Start and held for the whole run
//  Busy             out  1        high from the cycle after Start is accepted until Done
//  Done             out  1        one-cycle pulse when the last result has been written
//  X_read_en        out  1        ; X_read_address    out X_AW    ; X_read_data_out    in WIDTH
//  W_read_en        out  1        ; W_read_address    out W_AW    ; W_read_data_out    in WIDTH
//  sigm_read_en     out  1        ; sigm_read_address out SIGM_AW ; sigm_read_data_out in WIDTH
//  hRES_write_en    out  1        ; hRES_write_address out RES_AW ; hRES_write_data_in out WIDTH
// BEHAVIOUR
//  Reset: all outputs 0 (enables, addresses, data, Busy, Done); FSM goes to IDLE; counters r,n,i and the accumulator are cleared.
//    Reset mid-run aborts the run immediately. No further writes; no Done.
//  All RAMs are synchronous with 1-cycle read latency: address issued in cycle t, data is valid in cycle t+1.
//  Memory layout:
//    X[r][i] at address r*N_IN+i.
//    Biases B[n] at W address n; weight W[i][n] at (i+1)*N_NEURON+n.
//    OUT[r][n] at address r*N_NEURON+n.
//  FSM (order: neuron n inner, row r outer):
//   IDLE     : Start=1 -> clear r,n, latch act_bypass, set Busy -> BIAS_RD.
//   BIAS_RD  : W_read_en=1, W addr=n; clear acc and i -> MAC.
//   MAC      : cycle k=0..N_IN-1. X_read_en=W_read_en=1; X addr r*N_IN+k; W addr (k+1)*N_NEURON+n.
//              k=0: capture bias from W data. k>=1: acc += Xdata*Wdata for input k-1.
//              After k=N_IN-1 -> DRAIN.
//   DRAIN    : read enables 0; acc += product of input N_IN-1 -> SAT.
//   SAT      : idx = (acc>>ACC_SHIFT)+bias, clamped to 2^SIGM_AW-1 (never wraps).
//              sigm_read_en=1, sigm addr=idx -> WRITE.
//   WRITE    : hRES_write_en=1 for exactly this cycle; addr r*N_NEURON+n.
//              data = sigm_read_data_out, or idx[WIDTH-1:0] if bypass (idx clamped to 2^WIDTH-1 in bypass).
//              Then advance: n<N_NEURON-1 -> n+1, BIAS_RD.
//                            else n=0; r<N_ROWS-1 -> r+1, BIAS_RD; else DONE.
//   DONE     : Done=1 for one cycle, Busy=0 -> IDLE. Start held high re-triggers on the next IDLE cycle.
//  Latency: N_IN+4 cycles per result; total N_ROWS*N_NEURON*(N_IN+4)+1 cycles from Start to Done (defaults: 1409).
//  Arithmetic: unsigned. Accumulator width ACC_W = 2*WIDTH+clog2(N_IN); cannot overflow.
//    The bias add is done at ACC_W+1 bits before the clamp.
//  Start while Busy is ignored. act_bypass changes mid-run are ignored.
//  Write enable is 0 in every state except WRITE. Read enables are 0 outside their issuing states.
// STRUCTURE
//  Package dense_layer_pkg: FSM state localparams, ACC_W/index-width functions, address-map functions
//    (x_addr, w_addr, bias_addr, res_addr).
//  Sub-module mac_unit: WIDTH x WIDTH multiply plus ACC_W accumulator, with clr and en inputs.
//  Top holds the FSM, counters, clamp and output registers.
// TESTING
//  1. Defaults, X=all 1, W=all 1, B=0, LUT=identity -> sum 7 >>8 = 0; all 128 outputs 0; Done at cycle 1409 after Start.
//  2. X[r][i]=255, W=255, B=200 -> (7*65025)>>8=1778, +200 -> clamp 255; all outputs = LUT[255].
//  3. act_bypass=1, X[0][*]=16, W[*][0]=16, W[*][1]=32, B=(3,5) -> OUT[0][0]=3+7=10, OUT[0][1]=5+14=19.
//  4. Assert reset at cycle 500 mid-run -> no writes after the reset cycle, all outputs 0, no Done.
//     Next Start runs fully and correctly.
//  5. Override N_IN=3, N_NEURON=4, N_ROWS=5 -> check 20 writes at addresses 0..19 against a reference model;
//     total cycles 5*4*7+1=141.
//  6. Start held high throughout -> Done pulses every 1410 cycles; Start pulsed while Busy -> no effect.

Source files
------------

// File: rtl/dense_layer_engine_pkg.sv
// Shared types and address-map helpers for the dense layer engine and its MAC datapath.
package dense_layer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS_RD,
        ST_MAC,
        ST_DRAIN,
        ST_SAT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Wide enough for N_IN full-scale products, so the accumulator never overflows.
    function automatic int acc_width(input int width, input int n_in);
        return 2 * width + $clog2(n_in);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int x_addr(input int r, input int i, input int n_in);
        return r * n_in + i;
    endfunction

    // Biases occupy the first N_NEURON weight-RAM words; weights follow.
    function automatic int bias_addr(input int n);
        return n;
    endfunction

    function automatic int w_addr(input int i, input int n, input int n_neuron);
        return (i + 1) * n_neuron + n;
    endfunction

    function automatic int res_addr(input int r, input int n, input int n_neuron);
        return r * n_neuron + n;
    endfunction

endpackage

// File: rtl/dense_layer_engine_if.sv
// Control strobes and RAM-side ports of the dense layer engine; master is the engine side.
interface dense_layer_engine_if #(
    parameter int WIDTH   = 8,
    parameter int X_AW    = 9,
    parameter int W_AW    = 4,
    parameter int SIGM_AW = 8,
    parameter int RES_AW  = 7
);
    logic               Start;
    logic               act_bypass;
    logic               Busy;
    logic               Done;

    logic               X_read_en;
    logic [X_AW-1:0]    X_read_address;
    logic [WIDTH-1:0]   X_read_data_out;

    logic               W_read_en;
    logic [W_AW-1:0]    W_read_address;
    logic [WIDTH-1:0]   W_read_data_out;

    logic               sigm_read_en;
    logic [SIGM_AW-1:0] sigm_read_address;
    logic [WIDTH-1:0]   sigm_read_data_out;

    logic               hRES_write_en;
    logic [RES_AW-1:0]  hRES_write_address;
    logic [WIDTH-1:0]   hRES_write_data_in;

    modport master (
        input  Start, act_bypass,
        input  X_read_data_out, W_read_data_out, sigm_read_data_out,
        output Busy, Done,
        output X_read_en, X_read_address,
        output W_read_en, W_read_address,
        output sigm_read_en, sigm_read_address,
        output hRES_write_en, hRES_write_address, hRES_write_data_in
    );

    modport slave (
        output Start, act_bypass,
        output X_read_data_out, W_read_data_out, sigm_read_data_out,
        input  Busy, Done,
        input  X_read_en, X_read_address,
        input  W_read_en, W_read_address,
        input  sigm_read_en, sigm_read_address,
        input  hRES_write_en, hRES_write_address, hRES_write_data_in
    );

endinterface

// File: rtl/dense_layer_engine_mac.sv
// Unsigned multiply-accumulate; acc_sum is the running total including the current product.
module mac_unit
    import dense_layer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 7,
    parameter int ACC_W = acc_width(WIDTH, N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [ACC_W-1:0] acc_sum
);

    logic [ACC_W-1:0]   acc;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        acc_sum = acc + ACC_W'(prod);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/dense_layer_engine.sv
// Fully-connected layer sequencer: per (row, neuron) reads bias and weights, accumulates, clamps, activates, writes.
module dense_layer_engine
    import dense_layer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_IN      = 7,
    parameter int N_NEURON  = 2,
    parameter int N_ROWS    = 64,
    parameter int ACC_SHIFT = 8,
    parameter int X_AW      = 9,
    parameter int W_AW      = 4,
    parameter int SIGM_AW   = 8,
    parameter int RES_AW    = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    dense_layer_engine_if.master bus
);

    localparam int ACC_W = acc_width(WIDTH, N_IN);
    localparam int SUM_W = ACC_W + 1;
    localparam int R_W   = cnt_width(N_ROWS);
    localparam int N_W   = cnt_width(N_NEURON);
    localparam int K_W   = cnt_width(N_IN);

    localparam logic [SUM_W-1:0] SIGM_MAX = SUM_W'({SIGM_AW{1'b1}});
    localparam logic [SUM_W-1:0] DATA_MAX = SUM_W'({WIDTH{1'b1}});

    state_t             state;
    logic [R_W-1:0]     r;
    logic [N_W-1:0]     n;
    logic [K_W-1:0]     k;
    logic               bypass_q;
    logic [WIDTH-1:0]   bias_q;
    logic [WIDTH-1:0]   byp_data_q;

    logic               busy_q;
    logic               done_q;
    logic               x_en_q;
    logic               w_en_q;
    logic               sigm_en_q;
    logic               wr_en_q;
    logic [X_AW-1:0]    x_addr_q;
    logic [W_AW-1:0]    w_addr_q;
    logic [SIGM_AW-1:0] sigm_addr_q;
    logic [RES_AW-1:0]  wr_addr_q;

    logic               mac_clr;
    logic               mac_en;
    logic [ACC_W-1:0]   acc_sum;
    logic [SUM_W-1:0]   sum;
    logic [SIGM_AW-1:0] sigm_idx;
    logic [WIDTH-1:0]   byp_idx;

    always_comb begin
        mac_clr = (state == ST_BIAS_RD);
        mac_en  = ((state == ST_MAC) && (k != '0)) || (state == ST_DRAIN);
    end

    mac_unit #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       (bus.X_read_data_out),
        .b       (bus.W_read_data_out),
        .acc_sum (acc_sum)
    );

    // The clamp is evaluated from the final sum while draining so the LUT address is registered on entry to SAT.
    always_comb begin
        sum      = SUM_W'(acc_sum >> ACC_SHIFT) + SUM_W'(bias_q);
        sigm_idx = (sum > SIGM_MAX) ? SIGM_AW'(SIGM_MAX) : SIGM_AW'(sum);
        byp_idx  = (sum > DATA_MAX) ? WIDTH'(DATA_MAX) : WIDTH'(sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            r           <= '0;
            n           <= '0;
            k           <= '0;
            bypass_q    <= 1'b0;
            bias_q      <= '0;
            byp_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            x_en_q      <= 1'b0;
            w_en_q      <= 1'b0;
            sigm_en_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            x_addr_q    <= '0;
            w_addr_q    <= '0;
            sigm_addr_q <= '0;
            wr_addr_q   <= '0;
        end else begin
            x_en_q    <= 1'b0;
            w_en_q    <= 1'b0;
            sigm_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        r        <= '0;
                        n        <= '0;
                        bypass_q <= bus.act_bypass;
                        busy_q   <= 1'b1;
                        w_en_q   <= 1'b1;
                        w_addr_q <= W_AW'(bias_addr(0));
                        state    <= ST_BIAS_RD;
                    end
                end

                ST_BIAS_RD: begin
                    k        <= '0;
                    x_en_q   <= 1'b1;
                    w_en_q   <= 1'b1;
                    x_addr_q <= X_AW'(x_addr(int'(r), 0, N_IN));
                    w_addr_q <= W_AW'(w_addr(0, int'(n), N_NEURON));
                    state    <= ST_MAC;
                end

                ST_MAC: begin
                    if (k == '0) begin
                        bias_q <= bus.W_read_data_out;
                    end
                    if (k == K_W'(N_IN - 1)) begin
                        state <= ST_DRAIN;
                    end else begin
                        k        <= k + 1'b1;
                        x_en_q   <= 1'b1;
                        w_en_q   <= 1'b1;
                        x_addr_q <= X_AW'(x_addr(int'(r), int'(k) + 1, N_IN));
                        w_addr_q <= W_AW'(w_addr(int'(k) + 1, int'(n), N_NEURON));
                    end
                end

                ST_DRAIN: begin
                    sigm_en_q   <= 1'b1;
                    sigm_addr_q <= sigm_idx;
                    byp_data_q  <= byp_idx;
                    state       <= ST_SAT;
                end

                ST_SAT: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= RES_AW'(res_addr(int'(r), int'(n), N_NEURON));
                    state     <= ST_WRITE;
                end

                ST_WRITE: begin
                    if (n != N_W'(N_NEURON - 1)) begin
                        n        <= n + 1'b1;
                        w_en_q   <= 1'b1;
                        w_addr_q <= W_AW'(bias_addr(int'(n) + 1));
                        state    <= ST_BIAS_RD;
                    end else begin
                        n <= '0;
                        if (r != R_W'(N_ROWS - 1)) begin
                            r        <= r + 1'b1;
                            w_en_q   <= 1'b1;
                            w_addr_q <= W_AW'(bias_addr(0));
                            state    <= ST_BIAS_RD;
                        end else begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy               = busy_q;
    assign bus.Done               = done_q;
    assign bus.X_read_en          = x_en_q;
    assign bus.X_read_address     = x_addr_q;
    assign bus.W_read_en          = w_en_q;
    assign bus.W_read_address     = w_addr_q;
    assign bus.sigm_read_en       = sigm_en_q;
    assign bus.sigm_read_address  = sigm_addr_q;
    assign bus.hRES_write_en      = wr_en_q;
    assign bus.hRES_write_address = wr_addr_q;

    // NOTE: LUT data arrives in the WRITE cycle itself, so write data is a gated mux rather than a register;
    // gating on the write enable keeps the port at zero whenever no write is in flight.
    assign bus.hRES_write_data_in = !wr_en_q ? '0 : (bypass_q ? byp_data_q : bus.sigm_read_data_out);

endmodule

// File: tb/tb_dense_layer_engine.sv
// Scoreboard bench: default-size engine (A) for directed runs, reduced 3x4x5 engine (B) against a reference model.
module tb_dense_layer_engine;

    localparam int WIDTH   = 8;
    localparam int X_AW    = 9;
    localparam int W_AW    = 4;
    localparam int SIGM_AW = 8;
    localparam int RES_AW  = 7;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_a = 0;
    int   wr_a = 0;
    int   wr_b = 0;

    wr_t qa[$];
    wr_t qb[$];
    wr_t ea;
    wr_t eb;

    logic [WIDTH-1:0] xa_mem [512];
    logic [WIDTH-1:0] wa_mem [16];
    logic [WIDTH-1:0] xb_mem [512];
    logic [WIDTH-1:0] wb_mem [16];
    logic [WIDTH-1:0] lut    [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dense_layer_engine_if #(.WIDTH(WIDTH), .X_AW(X_AW), .W_AW(W_AW), .SIGM_AW(SIGM_AW), .RES_AW(RES_AW)) bus_a ();
    dense_layer_engine_if #(.WIDTH(WIDTH), .X_AW(X_AW), .W_AW(W_AW), .SIGM_AW(SIGM_AW), .RES_AW(RES_AW)) bus_b ();

    dense_layer_engine #(
        .WIDTH(WIDTH), .N_IN(7), .N_NEURON(2), .N_ROWS(64), .ACC_SHIFT(8),
        .X_AW(X_AW), .W_AW(W_AW), .SIGM_AW(SIGM_AW), .RES_AW(RES_AW)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    dense_layer_engine #(
        .WIDTH(WIDTH), .N_IN(3), .N_NEURON(4), .N_ROWS(5), .ACC_SHIFT(8),
        .X_AW(X_AW), .W_AW(W_AW), .SIGM_AW(SIGM_AW), .RES_AW(RES_AW)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Synchronous RAM models, one-cycle read latency.
    always @(posedge clk) begin
        if (bus_a.X_read_en)    bus_a.X_read_data_out    <= xa_mem[bus_a.X_read_address];
        if (bus_a.W_read_en)    bus_a.W_read_data_out    <= wa_mem[bus_a.W_read_address];
        if (bus_a.sigm_read_en) bus_a.sigm_read_data_out <= lut[bus_a.sigm_read_address];
        if (bus_b.X_read_en)    bus_b.X_read_data_out    <= xb_mem[bus_b.X_read_address];
        if (bus_b.W_read_en)    bus_b.W_read_data_out    <= wb_mem[bus_b.W_read_address];
        if (bus_b.sigm_read_en) bus_b.sigm_read_data_out <= lut[bus_b.sigm_read_address];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitors: pop the expected write whenever a DUT writes a result.
    always @(negedge clk) begin
        if (bus_a.hRES_write_en) begin
            wr_a++;
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_write addr=%0d data=%0d", bus_a.hRES_write_address, bus_a.hRES_write_data_in);
            end else begin
                ea = qa.pop_front();
                check("a_wr_addr", int'(bus_a.hRES_write_address), ea.addr);
                check("a_wr_data", int'(bus_a.hRES_write_data_in), ea.data);
            end
        end
        if (bus_a.Done) done_a++;
    end

    always @(negedge clk) begin
        if (bus_b.hRES_write_en) begin
            wr_b++;
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_write addr=%0d data=%0d", bus_b.hRES_write_address, bus_b.hRES_write_data_in);
            end else begin
                eb = qb.pop_front();
                check("b_wr_addr", int'(bus_b.hRES_write_address), eb.addr);
                check("b_wr_data", int'(bus_b.hRES_write_data_in), eb.data);
            end
        end
    end

    task automatic push_a(input int addr, input int data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        qa.push_back(e);
    endtask

    task automatic push_b(input int addr, input int data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        qb.push_back(e);
    endtask

    task automatic set_lut(input bit scrambled);
        for (int a = 0; a < 256; a++) lut[a] = scrambled ? 8'(a ^ 8'h5A) : 8'(a);
    endtask

    task automatic fill_a(input int xv, input int wv, input int b0, input int b1);
        for (int a = 0; a < 448; a++) xa_mem[a] = 8'(xv);
        for (int a = 0; a < 16; a++) wa_mem[a] = 8'(wv);
        wa_mem[0] = 8'(b0);
        wa_mem[1] = 8'(b1);
    endtask

    // Even rows X=16, odd rows X=32; neuron 0 weights 16, neuron 1 weights 32; biases 3 and 5.
    task automatic load_pattern3();
        for (int r = 0; r < 64; r++)
            for (int i = 0; i < 7; i++) xa_mem[r*7+i] = (r % 2 == 0) ? 8'd16 : 8'd32;
        wa_mem[0] = 8'd3;
        wa_mem[1] = 8'd5;
        for (int i = 0; i < 7; i++) begin
            wa_mem[(i+1)*2]   = 8'd16;
            wa_mem[(i+1)*2+1] = 8'd32;
        end
    endtask

    task automatic expect_pattern3();
        for (int r = 0; r < 64; r++) begin
            push_a(r*2,   (r % 2 == 0) ? 10 : 17);
            push_a(r*2+1, (r % 2 == 0) ? 19 : 33);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, int'({bus_a.Busy, bus_a.Done, bus_a.X_read_en, bus_a.W_read_en,
                                    bus_a.sigm_read_en, bus_a.hRES_write_en}), 0);
        check({tag, "_raddr"}, int'({bus_a.X_read_address, bus_a.W_read_address, bus_a.sigm_read_address}), 0);
        check({tag, "_waddr_data"}, int'({bus_a.hRES_write_address, bus_a.hRES_write_data_in}), 0);
    endtask

    // Start one run on A; optionally pulse Start and flip act_bypass mid-run (both must be ignored).
    task automatic run_a(input string tag, input int exp_cyc, input bit disturb);
        int  s;
        int  t;
        bit  seen;
        @(negedge clk);
        bus_a.Start = 1'b1;
        s = cyc;
        @(negedge clk);
        bus_a.Start = 1'b0;
        check({tag, "_busy"}, int'(bus_a.Busy), 1);
        seen = 1'b0;
        t = 0;
        while (!seen && t < exp_cyc + 100) begin
            if (disturb && t == 300) begin
                bus_a.Start = 1'b1;
                bus_a.act_bypass = ~bus_a.act_bypass;
            end
            if (disturb && t == 301) bus_a.Start = 1'b0;
            @(negedge clk);
            t++;
            if (bus_a.Done) seen = 1'b1;
        end
        check({tag, "_done_cycle"}, seen ? cyc - s : -1, exp_cyc);
        check({tag, "_busy_at_done"}, int'(bus_a.Busy), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(bus_a.Done), 0);
        check({tag, "_pending"}, qa.size(), 0);
    endtask

    initial begin
        int s;
        int t;
        int d0;
        int d1;
        int d2;
        int w0;
        int acc;
        int idx;

        bus_a.Start = 1'b0;
        bus_a.act_bypass = 1'b0;
        bus_b.Start = 1'b0;
        bus_b.act_bypass = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // 1: unit data, identity LUT -> every output 0
        fill_a(1, 1, 0, 0);
        set_lut(1'b0);
        for (int a = 0; a < 128; a++) push_a(a, 0);
        run_a("t1", 1409, 1'b0);

        // 2: full-scale data, sum 1978 clamps to 255 -> LUT[255] = 0xA5
        fill_a(255, 255, 200, 200);
        set_lut(1'b1);
        for (int a = 0; a < 128; a++) push_a(a, 8'hA5);
        run_a("t2", 1409, 1'b0);

        // 3: bypass; mid-run Start pulse and bypass flip have no effect
        load_pattern3();
        bus_a.act_bypass = 1'b1;
        expect_pattern3();
        run_a("t3", 1409, 1'b1);

        // 4: reset at cycle 500 -> 45 writes done (cycles 11..495), then nothing
        fill_a(255, 255, 200, 200);
        bus_a.act_bypass = 1'b0;
        for (int a = 0; a < 45; a++) push_a(a, 8'hA5);
        d0 = done_a;
        w0 = wr_a;
        @(negedge clk);
        bus_a.Start = 1'b1;
        s = cyc;
        @(negedge clk);
        bus_a.Start = 1'b0;
        while (cyc < s + 500) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("t4_reset");
        check("t4_writes_before_reset", wr_a - w0, 45);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_no_done", done_a - d0, 0);
        check("t4_idle_busy", int'(bus_a.Busy), 0);
        check("t4_writes_after_reset", wr_a - w0, 45);
        load_pattern3();
        bus_a.act_bypass = 1'b1;
        expect_pattern3();
        run_a("t4_rerun", 1409, 1'b0);

        // 6: Start held high -> back-to-back runs, Done 1410 cycles apart
        expect_pattern3();
        expect_pattern3();
        @(negedge clk);
        bus_a.Start = 1'b1;
        s = cyc;
        t = 0;
        while (!bus_a.Done && t < 1500) begin
            @(negedge clk);
            t++;
        end
        d1 = cyc;
        check("t6_first_done", d1 - s, 1409);
        repeat (2) @(negedge clk);
        check("t6_retrigger_busy", int'(bus_a.Busy), 1);
        bus_a.Start = 1'b0;
        t = 0;
        while (!bus_a.Done && t < 1500) begin
            @(negedge clk);
            t++;
        end
        d2 = cyc;
        check("t6_done_interval", d2 - d1, 1410);
        repeat (2) @(negedge clk);
        check("t6_stopped", int'(bus_a.Busy), 0);
        check("t6_pending", qa.size(), 0);

        // 5: reduced engine against the reference model
        set_lut(1'b1);
        for (int a = 0; a < 15; a++) xb_mem[a] = 8'((a / 3) * 37 + (a % 3) * 11 + 5);
        for (int a = 0; a < 16; a++) wb_mem[a] = 8'(a * 53 + 7);
        for (int r = 0; r < 5; r++) begin
            for (int n = 0; n < 4; n++) begin
                acc = 0;
                for (int i = 0; i < 3; i++) acc += int'(xb_mem[r*3+i]) * int'(wb_mem[(i+1)*4+n]);
                idx = (acc >> 8) + int'(wb_mem[n]);
                if (idx > 255) idx = 255;
                push_b(r*4+n, int'(lut[idx]));
            end
        end
        @(negedge clk);
        bus_b.Start = 1'b1;
        s = cyc;
        @(negedge clk);
        bus_b.Start = 1'b0;
        t = 0;
        while (!bus_b.Done && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("t5_done_cycle", bus_b.Done ? cyc - s : -1, 141);
        @(negedge clk);
        check("t5_writes", wr_b, 20);
        check("t5_pending", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
